// File: rtl/sparse_buf_ctrl_pkg.sv
// rtl/sparse_buf_ctrl_pkg.sv - shared types and constants for the sparse buffer controller
//
// Package sparse_pkg:
//   CSR_WORDS : words in one CSR tile (data, indices, row pointers)
//   SP_DW     : word width
//   state_t   : sequencer states
package sparse_pkg;

    localparam int CSR_WORDS = 35;
    localparam int SP_DW     = 32;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        GAP,
        ARB,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/sparse_buf_ctrl_if.sv
// rtl/sparse_buf_ctrl_if.sv - core-side request/grant and output stream bundle
//
// Signals:
//   req[1:0]   per-core tile request, held until granted
//   grant[1:0] one-hot owner of the current drain
//   out_valid, out_data, out_last, out_ready : output word stream
// Modports:
//   master : controller side (drives grant and the stream)
//   slave  : core side (drives req and out_ready)
interface sparse_buf_ctrl_if
    import sparse_pkg::*;
#(
    parameter int DW = SP_DW
) ();

    logic [1:0]    req;
    logic [1:0]    grant;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;

    modport master (
        input  req,
        input  out_ready,
        output grant,
        output out_valid,
        output out_data,
        output out_last
    );

    modport slave (
        output req,
        output out_ready,
        input  grant,
        input  out_valid,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/sparse_buf_ctrl_rr_arb2.sv
// rtl/sparse_buf_ctrl_rr_arb2.sv - two-requester round-robin arbiter
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   req[1:0] : requests
//   advance  : commit the current grant and rotate priority
//   gnt[1:0] : one-hot combinational grant (zero when no request)
module rr_arb2
    import sparse_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 0: core0 holds priority, 1: core1 holds priority
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt    = 2'b00;
        prio_d = prio_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        // The winner gives up priority to the other core.
        if (advance && (gnt != 2'b00)) begin
            prio_d = gnt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/sparse_buf_ctrl.sv
// rtl/sparse_buf_ctrl.sv - CSR tile fill sequencer and two-core drain arbiter
//
// Fetches one tile of WORDS words from the DMA stream into the sparse buffer,
// arbitrates the buffer load port between two cores and streams the tile out
// to the winner with valid/ready backpressure.
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   start                       : begin a tile fetch (only honoured in IDLE)
//   dma_valid/dma_data/dma_ready: DMA word stream in
//   buf_store_en/buf_store_data : buffer write port
//   buf_load_en/buf_data        : buffer read port (data one cycle after strobe)
//   buf_data_ready              : buffer reports the whole tile has been read
//   core                        : request/grant and output stream (master)
//   busy, tile_done, err        : status
// Optional (macro SPARSE_CTRL_PERF_EN):
//   perf_fill_cyc, perf_stall_cyc, perf_tiles : 32-bit performance counters
module sparse_buf_ctrl
    import sparse_pkg::*;
#(
    parameter int WORDS = CSR_WORDS,
    parameter int DW    = SP_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dma_valid,
    input  logic [DW-1:0]    dma_data,
    output logic             dma_ready,
    output logic             buf_store_en,
    output logic [DW-1:0]    buf_store_data,
    output logic             buf_load_en,
    input  logic [DW-1:0]    buf_data,
    input  logic             buf_data_ready,
    sparse_buf_ctrl_if.master core,
    output logic             busy,
    output logic             tile_done,
    output logic             err
`ifdef SPARSE_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_fill_cyc,
    output logic [31:0]      perf_stall_cyc,
    output logic [31:0]      perf_tiles
`endif
);

    localparam int CW = $clog2(WORDS + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WORDS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WORDS);

    state_t          state_q, state_d;
    logic [CW-1:0]   fill_q, fill_d;
    logic [CW-1:0]   issue_q, issue_d;
    logic [CW-1:0]   recv_q, recv_d;
    logic [1:0]      grant_q, grant_d;
    logic            valid_q, valid_d;
    logic            store_en_q, store_en_d;
    logic [DW-1:0]   store_data_q, store_data_d;
    logic            err_q, err_d;

    logic            dma_hs;
    logic            out_acc;
    logic            arb_advance;
    logic [1:0]      arb_gnt;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (core.req),
        .advance (arb_advance),
        .gnt     (arb_gnt)
    );

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        issue_d      = issue_q;
        recv_d       = recv_q;
        grant_d      = grant_q;
        valid_d      = 1'b0;
        store_en_d   = 1'b0;
        store_data_d = store_data_q;
        err_d        = err_q;
        arb_advance  = 1'b0;
        buf_load_en  = 1'b0;

        dma_ready = (state_q == FILL);
        dma_hs    = dma_valid & dma_ready;
        out_acc   = valid_q & core.out_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    fill_d  = '0;
                    issue_d = '0;
                    recv_d  = '0;
                end
            end
            FILL: begin
                if (dma_hs) begin
                    store_en_d   = 1'b1;
                    store_data_d = dma_data;
                    fill_d       = fill_q + CNT_ONE;
                    if (fill_q == CNT_LAST) begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                // Buffer rewinds its store pointer during this cycle.
                state_d = ARB;
            end
            ARB: begin
                if (core.req != 2'b00) begin
                    grant_d     = arb_gnt;
                    arb_advance = 1'b1;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                // Issue a load only when the output slot is free or being
                // emptied this cycle, so at most one word is ever in flight.
                buf_load_en = (issue_q < CNT_FULL) & (~valid_q | core.out_ready);
                if (buf_load_en) begin
                    issue_d = issue_q + CNT_ONE;
                end
                valid_d = buf_load_en | (valid_q & ~core.out_ready);
                if (out_acc) begin
                    recv_d = recv_q + CNT_ONE;
                    if (recv_q == CNT_LAST) begin
                        state_d = DONE;
                        grant_d = 2'b00;
                    end
                end
            end
            DONE: begin
                if (!buf_data_ready) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fill_q       <= '0;
            issue_q      <= '0;
            recv_q       <= '0;
            grant_q      <= 2'b00;
            valid_q      <= 1'b0;
            store_en_q   <= 1'b0;
            store_data_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            issue_q      <= issue_d;
            recv_q       <= recv_d;
            grant_q      <= grant_d;
            valid_q      <= valid_d;
            store_en_q   <= store_en_d;
            store_data_q <= store_data_d;
            err_q        <= err_d;
        end
    end

    assign buf_store_en   = store_en_q;
    assign buf_store_data = store_data_q;
    assign core.grant     = grant_q;
    assign core.out_valid = valid_q;
    // The buffer holds its word between loads; gate it so idle output reads zero.
    assign core.out_data  = valid_q ? buf_data : '0;
    assign core.out_last  = valid_q & (recv_q == CNT_LAST);
    assign busy           = (state_q != IDLE);
    assign tile_done      = (state_q == DONE);
    assign err            = err_q;

`ifdef SPARSE_CTRL_PERF_EN
    logic [31:0] perf_fill_q, perf_fill_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_tiles_q, perf_tiles_d;

    always_comb begin
        perf_fill_d  = perf_fill_q + {31'b0, (state_q == FILL)};
        perf_stall_d = perf_stall_q + {31'b0, (state_q == DRAIN) & valid_q & ~core.out_ready};
        perf_tiles_d = perf_tiles_q + {31'b0, (state_q == DONE)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fill_q  <= '0;
            perf_stall_q <= '0;
            perf_tiles_q <= '0;
        end else begin
            perf_fill_q  <= perf_fill_d;
            perf_stall_q <= perf_stall_d;
            perf_tiles_q <= perf_tiles_d;
        end
    end

    assign perf_fill_cyc  = perf_fill_q;
    assign perf_stall_cyc = perf_stall_q;
    assign perf_tiles     = perf_tiles_q;
`endif

endmodule

// File: tb/tb_sparse_buf_ctrl.sv
// tb/tb_sparse_buf_ctrl.sv - self-checking bench for sparse_buf_ctrl
module tb_sparse_buf_ctrl;

    localparam int W = 35;
    localparam int P_IDLE = 0, P_FILL = 1, P_GAP = 2, P_ARB = 3, P_DRAIN = 4, P_DONE = 5;

    logic        clk = 1'b0;
    logic        rst, start, dma_valid, dma_ready;
    logic [31:0] dma_data, buf_store_data, buf_data;
    logic        buf_store_en, buf_load_en, buf_data_ready;
    logic        busy, tile_done, err;
    logic [1:0]  req_r;
    logic        rdy_r;
    bit          force_low;

    int n_chk = 0;
    int n_fail = 0;

    sparse_buf_ctrl_if ifc ();
    assign ifc.req       = req_r;
    assign ifc.out_ready = rdy_r;

`ifdef SPARSE_CTRL_PERF_EN
    logic [31:0] perf_fill_cyc, perf_stall_cyc, perf_tiles;
`endif

    always #5 clk = ~clk;

    sparse_buf_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .dma_valid      (dma_valid),
        .dma_data       (dma_data),
        .dma_ready      (dma_ready),
        .buf_store_en   (buf_store_en),
        .buf_store_data (buf_store_data),
        .buf_load_en    (buf_load_en),
        .buf_data       (buf_data),
        .buf_data_ready (buf_data_ready),
        .core           (ifc),
        .busy           (busy),
        .tile_done      (tile_done),
        .err            (err)
`ifdef SPARSE_CTRL_PERF_EN
        ,
        .perf_fill_cyc  (perf_fill_cyc),
        .perf_stall_cyc (perf_stall_cyc),
        .perf_tiles     (perf_tiles)
`endif
    );

    // Sparse buffer stand-in: sequential store, sequential load, word one cycle after strobe.
    logic [31:0] mem [W];
    int wp, rp, rd_cnt;
    always @(posedge clk) begin
        if (rst) begin
            wp <= 0; rp <= 0; rd_cnt <= 0; buf_data <= '0;
        end else begin
            if (buf_store_en) begin
                mem[wp] <= buf_store_data; wp <= (wp + 1) % W; rd_cnt <= 0;
            end
            if (buf_load_en) begin
                buf_data <= mem[rp]; rp <= (rp + 1) % W; rd_cnt <= rd_cnt + 1;
            end
        end
    end
    assign buf_data_ready = (rd_cnt == W) && !force_low;

    // Behavioural reference: phase, counters and the tile contents as plain ints/arrays.
    int          m_phase = P_IDLE, m_fill = 0, m_issue = 0, m_recv = 0, m_win = 0;
    bit          m_ov = 0, m_se = 0, m_err = 0, m_pri = 0, m_ld, m_acc;
    logic [31:0] m_sd = '0;
    logic [1:0]  m_grant = 2'b00;
    logic [31:0] m_tile [W];

    function automatic bit m_load();
        return (m_phase == P_DRAIN) && (m_issue < W) && (!m_ov || rdy_r);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = P_IDLE; m_fill = 0; m_issue = 0; m_recv = 0;
            m_ov = 0; m_se = 0; m_err = 0; m_pri = 0; m_sd = '0; m_grant = 2'b00;
        end else begin
            m_ld  = m_load();
            m_acc = (m_phase == P_DRAIN) && m_ov && rdy_r;
            m_se  = (m_phase == P_FILL) && dma_valid;
            if (m_se) m_sd = dma_data;
            case (m_phase)
                P_IDLE: if (start) begin
                    m_phase = P_FILL; m_fill = 0; m_issue = 0; m_recv = 0;
                end
                P_FILL: if (dma_valid) begin
                    m_tile[m_fill] = dma_data;
                    m_fill++;
                    if (m_fill == W) m_phase = P_GAP;
                end
                P_GAP: m_phase = P_ARB;
                P_ARB: if (req_r != 2'b00) begin
                    m_win   = (req_r == 2'b11) ? int'(m_pri) : (req_r[1] ? 1 : 0);
                    m_grant = 2'(1 << m_win);
                    m_pri   = (m_win == 0);
                    m_phase = P_DRAIN;
                end
                P_DRAIN: begin
                    if (m_ld) m_issue++;
                    if (m_acc) begin
                        m_recv++;
                        if (m_recv == W) begin m_phase = P_DONE; m_grant = 2'b00; end
                    end
                    m_ov = m_ld || (m_ov && !rdy_r);
                end
                P_DONE: begin
                    if (!buf_data_ready) m_err = 1;
                    m_phase = P_IDLE;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("dma_ready", dma_ready, m_phase == P_FILL);
        chk("buf_store_en", buf_store_en, m_se);
        if (m_se) chk("buf_store_data", buf_store_data, m_sd);
        chk("buf_load_en", buf_load_en, m_load());
        chk("grant", ifc.grant, m_grant);
        chk("out_valid", ifc.out_valid, m_ov);
        if (m_ov && m_recv < W) chk("out_data", ifc.out_data, m_tile[m_recv]);
        chk("out_last", ifc.out_last, m_ov && (m_recv == W - 1));
        chk("busy", busy, m_phase != P_IDLE);
        chk("tile_done", tile_done, m_phase == P_DONE);
        chk("err", err, m_err);
    endtask

    // One clock: check outputs on the falling edge, return just after the rising edge.
    task automatic cyc();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  r_g;
    int          r_fill, r_nst, r_arb, r_drain, r_acc;
    logic [31:0] r_last;

    task automatic do_reset();
        req_r = 2'b00; rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic run_tile(input int vmode, input int rmode, input logic [1:0] rq,
                            input bit seq, input int abort_at, input bit ign_start);
        int cnt, stl;
        bit rdy_pre;
        r_fill = 0; r_nst = 0; r_arb = 0; r_drain = 0; r_acc = 0; r_last = '0; r_g = 2'b00;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_to_dma_ready", dma_ready, 1'b1);
        cnt = 0;
        while (cnt < W && r_fill < 400) begin
            case (vmode)
                0:       dma_valid = 1'b1;
                1:       dma_valid = (r_fill % 2) == 1;
                default: dma_valid = 1'($urandom_range(0, 1));
            endcase
            dma_data = seq ? 32'(cnt) : $urandom;
            rdy_pre  = dma_ready;
            cyc();
            if (dma_valid && rdy_pre) cnt++;
            if (buf_store_en) r_nst++;
            r_fill++;
        end
        dma_valid = 1'b0;
        if (cnt != W) chk("fill_words", cnt, W);
        req_r = req_r | rq;
        while (ifc.grant == 2'b00 && r_arb < 50) begin
            cyc();
            r_arb++;
            if (buf_store_en) r_nst++;
        end
        r_g   = ifc.grant;
        req_r = req_r & ~r_g;
        stl   = 0;
        while (!tile_done && r_drain < 2000) begin
            if (abort_at >= 0 && r_acc == abort_at) begin
                rst = 1'b1; req_r = 2'b00;
                cyc();
                rst = 1'b0;
                return;
            end
            case (rmode)
                0: rdy_r = 1'b1;
                1: rdy_r = ($urandom_range(0, 3) != 0);
                default: begin
                    if (seq && r_acc == 10 && ifc.out_valid)
                        chk("stall_hold_data", ifc.out_data, 32'd10);
                    if (r_acc == 10 && ifc.out_valid && stl < 3) begin
                        rdy_r = 1'b0; stl++;
                    end else begin
                        rdy_r = 1'b1;
                    end
                end
            endcase
            start = ign_start && (r_drain == 5);
            if (ifc.out_valid && rdy_r) begin
                r_acc++;
                if (ifc.out_last) r_last = ifc.out_data;
            end
            cyc();
            r_drain++;
        end
        start = 1'b0; rdy_r = 1'b1;
        chk("tile_done_seen", tile_done, 1'b1);
        cyc();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dma_valid = 1'b0; dma_data = '0;
        req_r = 2'b00; rdy_r = 1'b1; force_low = 0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("rst_dma_ready", dma_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", ifc.grant, 2'b00);
        chk("rst_out_valid", ifc.out_valid, 1'b0);
        chk("rst_err", err, 1'b0);

        // Single tile, back-to-back DMA, no stall.
        run_tile(0, 0, 2'b01, 1, -1, 0);
        chk("a_grant", r_g, 2'b01);
        chk("a_fill_cycles", r_fill, 35);
        chk("a_store_count", r_nst, 35);
        chk("a_gap_arb_cycles", r_arb, 2);
        chk("a_drain_cycles", r_drain, 36);
        chk("a_words", r_acc, 35);
        chk("a_last_word", r_last, 32'h22);
        chk("a_err", err, 1'b0);

        // DMA bubbles every other cycle.
        run_tile(1, 0, 2'b01, 1, -1, 0);
        chk("b_fill_cycles", r_fill, 70);
        chk("b_grant", r_g, 2'b01);
        chk("b_words", r_acc, 35);

        // Three-cycle output stall at word 10.
        run_tile(0, 2, 2'b01, 1, -1, 0);
        chk("c_words", r_acc, 35);
        chk("c_drain_cycles", r_drain, 39);
        chk("c_last_word", r_last, 32'h22);

        // Both cores request on consecutive tiles.
        do_reset();
        run_tile(0, 0, 2'b11, 1, -1, 0);
        chk("d_grant", r_g, 2'b01);
        run_tile(0, 1, 2'b11, 0, -1, 0);
        chk("e_grant", r_g, 2'b10);
        chk("e_words", r_acc, 35);

        // Reset in the middle of the drain, then a fresh tile.
        run_tile(0, 0, 2'b01, 1, 20, 0);
        chk("f_busy", busy, 1'b0);
        chk("f_out_valid", ifc.out_valid, 1'b0);
        chk("f_out_data", ifc.out_data, 32'h0);
        chk("f_grant", ifc.grant, 2'b00);
        chk("f_load_en", buf_load_en, 1'b0);
        chk("f_store_en", buf_store_en, 1'b0);
        run_tile(2, 1, 2'b01, 0, -1, 0);
        chk("g_grant", r_g, 2'b01);
        chk("g_words", r_acc, 35);

        // Stray start during drain, buffer not ready at DONE.
        force_low = 1;
        run_tile(0, 0, 2'b10, 1, -1, 1);
        force_low = 0;
        chk("h_grant", r_g, 2'b10);
        chk("h_words", r_acc, 35);
        chk("h_err_set", err, 1'b1);
        run_tile(0, 0, 2'b01, 1, -1, 0);
        chk("i_err_sticky", err, 1'b1);
        do_reset();
        chk("i_err_cleared", err, 1'b0);

        // Randomised tiles.
        for (int k = 0; k < 6; k++) begin
            run_tile(2, 1, 2'($urandom_range(1, 3)), 0, -1, 0);
            chk("rand_words", r_acc, 35);
            chk("rand_grant_onehot", 32'($onehot(r_g)), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
